// File: rtl/pwm_ramp_ctrl.sv
// Duty-cycle ramp sequencer: accepts a target duty over valid/ready and slews the PWM duty
// toward it by STEP counts every DIV period_done pulses. Optional sticky irq via `PWM_RAMP_IRQ_EN.
module pwm_ramp_ctrl #(
    parameter int DW   = 8,
    parameter int STEP = 4,
    parameter int DIV  = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [DW-1:0] cmd_duty,
    input  logic          period_done,
    output logic [DW-1:0] duty,
    output logic          busy,
    output logic          done
`ifdef PWM_RAMP_IRQ_EN
    ,
    output logic          irq,
    input  logic          irq_clr
`endif
);

    localparam int            PW         = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
    localparam logic [DW:0]   STEP_X     = (DW + 1)'(STEP);
    localparam logic [DW-1:0] STEP_D     = DW'(STEP);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RAMP = 1'b1;

    logic [0:0]    r_state_reg,  r_state_next;
    logic [DW-1:0] r_duty_reg,   r_duty_next;
    logic [DW-1:0] r_target_reg, r_target_next;
    logic [PW-1:0] r_presc_reg,  r_presc_next;
    logic          r_done_reg,   r_done_next;

    logic          w_up;
    logic [DW:0]   w_diff;
    logic          w_last_step;
    logic [DW-1:0] w_stepped;
    logic          w_tick;

    // Distance is formed in DW+1 bits so a full-scale gap never aliases to a small one;
    // whenever it exceeds STEP the full step cannot overshoot, so duty never wraps.
    always_comb begin
        w_up        = (r_target_reg > r_duty_reg);
        w_diff      = w_up ? ({1'b0, r_target_reg} - {1'b0, r_duty_reg})
                           : ({1'b0, r_duty_reg} - {1'b0, r_target_reg});
        w_last_step = (w_diff <= STEP_X);
        w_stepped   = w_up ? (r_duty_reg + STEP_D) : (r_duty_reg - STEP_D);
        w_tick      = period_done & enable & (r_state_reg == ST_RAMP);
    end

    always_comb begin
        r_state_next  = r_state_reg;
        r_duty_next   = r_duty_reg;
        r_target_next = r_target_reg;
        r_presc_next  = r_presc_reg;
        r_done_next   = 1'b0;
        case (r_state_reg)
            ST_IDLE: begin
                if (cmd_valid) begin
                    r_target_next = cmd_duty;
                    if (cmd_duty == r_duty_reg) begin
                        r_done_next = 1'b1;
                    end else begin
                        r_state_next = ST_RAMP;
                        r_presc_next = '0;
                    end
                end
            end
            ST_RAMP: begin
                if (w_tick) begin
                    if (r_presc_reg == PRESC_LAST) begin
                        r_presc_next = '0;
                        if (w_last_step) begin
                            r_duty_next  = r_target_reg;
                            r_state_next = ST_IDLE;
                            r_done_next  = 1'b1;
                        end else begin
                            r_duty_next = w_stepped;
                        end
                    end else begin
                        r_presc_next = r_presc_reg + PW'(1);
                    end
                end
            end
            default: r_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_reg  <= ST_IDLE;
            r_duty_reg   <= '0;
            r_target_reg <= '0;
            r_presc_reg  <= '0;
            r_done_reg   <= 1'b0;
        end else begin
            r_state_reg  <= r_state_next;
            r_duty_reg   <= r_duty_next;
            r_target_reg <= r_target_next;
            r_presc_reg  <= r_presc_next;
            r_done_reg   <= r_done_next;
        end
    end

    assign cmd_ready = (r_state_reg == ST_IDLE);
    assign busy      = (r_state_reg == ST_RAMP);
    assign duty      = r_duty_reg;
    assign done      = r_done_reg;

`ifdef PWM_RAMP_IRQ_EN
    logic r_irq_reg;

    // A completion on the same edge as irq_clr keeps the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_irq_reg <= 1'b0;
        end else if (r_done_next) begin
            r_irq_reg <= 1'b1;
        end else if (irq_clr) begin
            r_irq_reg <= 1'b0;
        end
    end

    assign irq = r_irq_reg;
`endif

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Scoreboard bench for pwm_ramp_ctrl: stimulus queues expected duty/done events tagged with
// the period_done pulse index; a negedge monitor pops and compares each observed event.
module tb_pwm_ramp_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [7:0] cmd_duty = 8'd0;
    logic       period_done = 1'b0;
    logic [7:0] duty;
    logic       busy;
    logic       done;
    logic       irq_clr = 1'b0;
`ifdef PWM_RAMP_IRQ_EN
    logic       irq;
`endif

    pwm_ramp_ctrl #(.DW(8), .STEP(4), .DIV(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_duty    (cmd_duty),
        .period_done (period_done),
        .duty        (duty),
        .busy        (busy),
        .done        (done)
`ifdef PWM_RAMP_IRQ_EN
        ,
        .irq         (irq),
        .irq_clr     (irq_clr)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       is_done;
        bit [7:0] val;
        int       pulse;   // -1: pulse index not checked
    } ev_t;

    ev_t  exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   pulse_cnt = 0;
    bit   mon_en = 1'b0;
    logic [7:0] prev_duty;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", name, act, req);
        end else begin
            $display("ok   %s = %0d", name, act);
        end
    endtask

    task automatic exp_ev(input bit is_done, input bit [7:0] val, input int pulse);
        ev_t e;
        e.is_done = is_done;
        e.val     = val;
        e.pulse   = pulse;
        exp_q.push_back(e);
    endtask

    task automatic observe(input bit is_done, input bit [7:0] val);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL event unexpected %s duty=%0d pulse=%0d t=%0t",
                     is_done ? "done" : "duty", val, pulse_cnt, $time);
            return;
        end
        e = exp_q.pop_front();
        if (e.is_done != is_done || e.val != val || (e.pulse >= 0 && e.pulse != pulse_cnt)) begin
            failures++;
            $display("FAIL event got %s duty=%0d pulse=%0d want %s duty=%0d pulse=%0d",
                     is_done ? "done" : "duty", val, pulse_cnt,
                     e.is_done ? "done" : "duty", e.val, e.pulse);
        end else begin
            $display("ok   event %s duty=%0d pulse=%0d", is_done ? "done" : "duty", val, pulse_cnt);
        end
    endtask

    // Monitor: a duty change or a done pulse is a DUT output event.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (duty !== prev_duty) observe(1'b0, duty);
                if (done !== 1'b0) observe(1'b1, duty);
            end
            prev_duty = duty;
        end
    end

    task automatic cmd(input logic [7:0] v, input bit clr);
        @(posedge clk); #1;
        pulse_cnt = 0;
        cmd_valid = 1'b1;
        cmd_duty  = v;
        irq_clr   = clr;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        irq_clr   = 1'b0;
    endtask

    task automatic pulse(input bit counted);
        @(posedge clk); #1;
        period_done = 1'b1;
        if (counted) pulse_cnt++;
        @(posedge clk); #1;
        period_done = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic pulse_rst();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: reset
        repeat (3) @(posedge clk);
        #1;
        chk("rst_duty", duty, 0);
        chk("rst_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
`ifdef PWM_RAMP_IRQ_EN
        chk("rst_irq", irq, 0);
`endif
        rst = 1'b0;
        @(posedge clk); #1;
        mon_en = 1'b1;

        // 2: 0 -> 16
        for (int k = 1; k <= 4; k++) exp_ev(1'b0, 8'(4 * k), 2 * k);
        exp_ev(1'b1, 8'd16, 8);
        cmd(8'd16, 1'b0);
        chk("t2_busy", busy, 1);
        chk("t2_ready", cmd_ready, 0);
        for (int i = 0; i < 8; i++) pulse(1'b1);
        chk("t2_duty", duty, 16);
        chk("t2_ready_end", cmd_ready, 1);
        chk("t2_busy_end", busy, 0);
`ifdef PWM_RAMP_IRQ_EN
        chk("t2_irq_set", irq, 1);
        @(posedge clk); #1; irq_clr = 1'b1;
        @(posedge clk); #1; irq_clr = 1'b0;
        chk("t2_irq_clr", irq, 0);
`endif
        // period_done in IDLE: no events expected
        pulse(1'b0);
        pulse(1'b0);

        // 3: 16 -> 6, partial last step
        exp_ev(1'b0, 8'd12, 2);
        exp_ev(1'b0, 8'd8, 4);
        exp_ev(1'b0, 8'd6, 6);
        exp_ev(1'b1, 8'd6, 6);
        cmd(8'd6, 1'b0);
        for (int i = 0; i < 6; i++) pulse(1'b1);
        chk("t3_duty", duty, 6);

        // 4: equal target, done one cycle after accept (irq set beats clear)
        exp_ev(1'b1, 8'd6, 0);
        cmd(8'd6, 1'b1);
        chk("t4_busy", busy, 0);
        @(posedge clk); #1;
        chk("t4_ready", cmd_ready, 1);
`ifdef PWM_RAMP_IRQ_EN
        chk("t4_irq_tie", irq, 1);
        @(posedge clk); #1; irq_clr = 1'b1;
        @(posedge clk); #1; irq_clr = 1'b0;
`endif
        // 6 -> 250 with a competing command held during the ramp
        for (int k = 1; k <= 61; k++) exp_ev(1'b0, 8'(6 + 4 * k), 2 * k);
        exp_ev(1'b1, 8'd250, 122);
        cmd(8'd250, 1'b0);
        cmd_valid = 1'b1;
        cmd_duty  = 8'd100;
        for (int i = 0; i < 10; i++) pulse(1'b1);
        chk("t4_ready_ramp", cmd_ready, 0);
        cmd_valid = 1'b0;
        for (int i = 10; i < 122; i++) pulse(1'b1);
        chk("t4_duty", duty, 250);

        // 5: 250 -> 255, no wrap, freeze with enable=0 mid-ramp
        exp_ev(1'b0, 8'd254, 2);
        exp_ev(1'b0, 8'd255, 4);
        exp_ev(1'b1, 8'd255, 4);
        cmd(8'd255, 1'b0);
        for (int i = 0; i < 3; i++) pulse(1'b1);
        enable = 1'b0;
        for (int i = 0; i < 5; i++) pulse(1'b0);
        chk("t5_frozen", duty, 254);
        chk("t5_busy", busy, 1);
        enable = 1'b1;
        pulse(1'b1);
        chk("t5_duty", duty, 255);

        // 6: reset to 0, ramp toward 200, abort at 40
        exp_ev(1'b0, 8'd0, -1);
        pulse_rst();
        for (int k = 1; k <= 10; k++) exp_ev(1'b0, 8'(4 * k), 2 * k);
        cmd(8'd200, 1'b0);
        for (int i = 0; i < 20; i++) pulse(1'b1);
        chk("t6_duty40", duty, 40);
        exp_ev(1'b0, 8'd0, -1);
        pulse_rst();
        chk("t6_duty", duty, 0);
        chk("t6_ready", cmd_ready, 1);
        chk("t6_busy", busy, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("t6_queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
